bcd_countdown_ctl: RTL and testbench

//   Two-digit BCD countdown timer with an integrated start/pause/clear control FSM.

---
 rtl/bcd_countdown_ctl.sv | 156 +++++++++++++++
 tb/tb_bcd_countdown_ctl.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/bcd_countdown_ctl.sv
// Two-digit BCD countdown timer with start/pause/clear control FSM.
// Consumes one-cycle button pulses and a 1 Hz tick; all outputs are registered.
module bcd_countdown_ctl #(
  parameter int BCD_W     = 4,
  parameter int INIT_TENS = 3,
  parameter int INIT_ONES = 0,
  parameter int WRAP      = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             start_stop,
  input  logic             clear,
  input  logic             load,
  input  logic [BCD_W-1:0] preset_tens,
  input  logic [BCD_W-1:0] preset_ones,
  output logic [BCD_W-1:0] digit1,
  output logic [BCD_W-1:0] digit0,
  output logic             running,
  output logic             done,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [BCD_W-1:0] NINE     = BCD_W'(9);
  localparam logic [BCD_W-1:0] ZERO     = '0;
  localparam logic [BCD_W-1:0] ONE      = BCD_W'(1);
  localparam logic [BCD_W-1:0] INIT_T   = BCD_W'(INIT_TENS);
  localparam logic [BCD_W-1:0] INIT_O   = BCD_W'(INIT_ONES);

  state_t           state_reg, state_next;
  logic [BCD_W-1:0] tens_reg, tens_next;
  logic [BCD_W-1:0] ones_reg, ones_next;
  logic [BCD_W-1:0] pre_tens_reg, pre_tens_next;
  logic [BCD_W-1:0] pre_ones_reg, pre_ones_next;
  logic             done_reg, done_next;
  logic             running_reg, running_next;

  // Index 0 = ones, 1 = tens; out-of-range preset digits saturate at 9.
  logic [BCD_W-1:0] preset_raw [2];
  logic [BCD_W-1:0] preset_clamped [2];

  assign preset_raw[0] = preset_ones;
  assign preset_raw[1] = preset_tens;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_clamp
      assign preset_clamped[gi] = (preset_raw[gi] > NINE) ? NINE : preset_raw[gi];
    end
  endgenerate

  logic             at_zero;
  logic [BCD_W-1:0] dec_tens;
  logic [BCD_W-1:0] dec_ones;
  logic             dec_hits_zero;
  logic             load_ok;

  assign at_zero       = (tens_reg == ZERO) && (ones_reg == ZERO);
  assign dec_ones      = (ones_reg != ZERO) ? (ones_reg - ONE) : NINE;
  assign dec_tens      = (ones_reg != ZERO) ? tens_reg : (tens_reg - ONE);
  assign dec_hits_zero = (tens_reg == ZERO) && (ones_reg == ONE);
  assign load_ok       = (state_reg == ST_IDLE) || (state_reg == ST_PAUSE);

  always_comb begin
    state_next    = state_reg;
    tens_next     = tens_reg;
    ones_next     = ones_reg;
    pre_tens_next = pre_tens_reg;
    pre_ones_next = pre_ones_reg;
    done_next     = 1'b0;

    if (clear) begin
      state_next    = ST_IDLE;
      pre_tens_next = INIT_T;
      pre_ones_next = INIT_O;
      tens_next     = INIT_T;
      ones_next     = INIT_O;
    end else if (load && load_ok) begin
      pre_tens_next = preset_clamped[1];
      pre_ones_next = preset_clamped[0];
      tens_next     = preset_clamped[1];
      ones_next     = preset_clamped[0];
    end else if (start_stop) begin
      unique case (state_reg)
        ST_IDLE: begin
          if (at_zero) begin
            state_next = ST_DONE;
            done_next  = 1'b1;
          end else begin
            state_next = ST_RUN;
          end
        end
        ST_RUN:   state_next = ST_PAUSE;
        ST_PAUSE: state_next = ST_RUN;
        ST_DONE: begin
          tens_next  = pre_tens_reg;
          ones_next  = pre_ones_reg;
          state_next = ST_RUN;
        end
        default:  state_next = ST_IDLE;
      endcase
    end else if (tick && (state_reg == ST_RUN)) begin
      // At 00 only wrap mode moves; otherwise the count never underflows.
      if (at_zero) begin
        if (WRAP != 0) begin
          tens_next = pre_tens_reg;
          ones_next = pre_ones_reg;
        end
      end else begin
        tens_next = dec_tens;
        ones_next = dec_ones;
        if (dec_hits_zero) begin
          done_next = 1'b1;
          if (WRAP == 0) begin
            state_next = ST_DONE;
          end
        end
      end
    end

    running_next = (state_next == ST_RUN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      tens_reg     <= INIT_T;
      ones_reg     <= INIT_O;
      pre_tens_reg <= INIT_T;
      pre_ones_reg <= INIT_O;
      done_reg     <= 1'b0;
      running_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      tens_reg     <= tens_next;
      ones_reg     <= ones_next;
      pre_tens_reg <= pre_tens_next;
      pre_ones_reg <= pre_ones_next;
      done_reg     <= done_next;
      running_reg  <= running_next;
    end
  end

  assign digit1  = tens_reg;
  assign digit0  = ones_reg;
  assign running = running_reg;
  assign done    = done_reg;
  assign state   = state_reg;

endmodule

// File: tb/tb_bcd_countdown_ctl.sv
// Bench for bcd_countdown_ctl: a WRAP=0 and a WRAP=1 instance share stimulus and
// are compared each cycle against an integer-count reference model.
module tb_bcd_countdown_ctl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0;
  logic       start_stop = 1'b0;
  logic       clear = 1'b0;
  logic       load = 1'b0;
  logic [3:0] preset_tens = 4'd0;
  logic [3:0] preset_ones = 4'd0;

  logic [3:0] digit1_w [2];
  logic [3:0] digit0_w [2];
  logic       running_w [2];
  logic       done_w [2];
  logic [1:0] state_w [2];

  int n_cmp = 0;
  int n_bad = 0;

  // Model: count as plain integer 0..99, preset likewise.
  int m_count [2];
  int m_preset [2];
  int m_state [2];
  int m_done [2];

  always #5 clk = ~clk;

  bcd_countdown_ctl #(.BCD_W(4), .INIT_TENS(3), .INIT_ONES(0), .WRAP(0)) dut0 (
    .clk(clk), .rst(rst), .tick(tick), .start_stop(start_stop), .clear(clear),
    .load(load), .preset_tens(preset_tens), .preset_ones(preset_ones),
    .digit1(digit1_w[0]), .digit0(digit0_w[0]), .running(running_w[0]),
    .done(done_w[0]), .state(state_w[0])
  );

  bcd_countdown_ctl #(.BCD_W(4), .INIT_TENS(3), .INIT_ONES(0), .WRAP(1)) dut1 (
    .clk(clk), .rst(rst), .tick(tick), .start_stop(start_stop), .clear(clear),
    .load(load), .preset_tens(preset_tens), .preset_ones(preset_ones),
    .digit1(digit1_w[1]), .digit0(digit0_w[1]), .running(running_w[1]),
    .done(done_w[1]), .state(state_w[1])
  );

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_count[k] = 30; m_preset[k] = 30; m_state[k] = 0; m_done[k] = 0;
    end
  endtask

  function automatic int min9(input int v);
    return (v > 9) ? 9 : v;
  endfunction

  task automatic model_step(input int k, input bit c, input bit l, input bit s,
                            input bit t, input int pt, input int po);
    m_done[k] = 0;
    if (c) begin
      m_state[k] = 0; m_preset[k] = 30; m_count[k] = 30;
    end else if (l && (m_state[k] == 0 || m_state[k] == 2)) begin
      m_preset[k] = min9(pt) * 10 + min9(po);
      m_count[k]  = m_preset[k];
    end else if (s) begin
      if (m_state[k] == 0) begin
        if (m_count[k] == 0) begin m_state[k] = 3; m_done[k] = 1; end
        else m_state[k] = 1;
      end else if (m_state[k] == 1) m_state[k] = 2;
      else if (m_state[k] == 2) m_state[k] = 1;
      else begin m_count[k] = m_preset[k]; m_state[k] = 1; end
    end else if (t && m_state[k] == 1) begin
      if (m_count[k] == 0) begin
        if (k == 1) m_count[k] = m_preset[k];
      end else begin
        m_count[k] = m_count[k] - 1;
        if (m_count[k] == 0) begin
          m_done[k] = 1;
          if (k == 0) m_state[k] = 3;
        end
      end
    end
  endtask

  task automatic check_all(input string tag);
    for (int k = 0; k < 2; k++) begin
      string p;
      p = $sformatf("%s/w%0d", tag, k);
      check({p, "/digit1"},  int'(digit1_w[k]),  m_count[k] / 10);
      check({p, "/digit0"},  int'(digit0_w[k]),  m_count[k] % 10);
      check({p, "/state"},   int'(state_w[k]),   m_state[k]);
      check({p, "/running"}, int'(running_w[k]), (m_state[k] == 1) ? 1 : 0);
      check({p, "/done"},    int'(done_w[k]),    m_done[k]);
    end
  endtask

  // Drive one cycle of inputs, advance the model at the edge, compare #1 later.
  task automatic step(input string tag, input bit c, input bit l, input bit s,
                      input bit t, input int pt, input int po);
    clear = c; load = l; start_stop = s; tick = t;
    preset_tens = 4'(pt); preset_ones = 4'(po);
    @(posedge clk);
    for (int k = 0; k < 2; k++) model_step(k, c, l, s, t, pt, po);
    #1;
    clear = 0; load = 0; start_stop = 0; tick = 0;
    check_all(tag);
    $display("txn %-10s clr=%0d ld=%0d ss=%0d tk=%0d pre=%0d%0d -> w0=%0d%0d st%0d d%0d | w1=%0d%0d st%0d d%0d",
             tag, c, l, s, t, pt, po, digit1_w[0], digit0_w[0], state_w[0], done_w[0],
             digit1_w[1], digit0_w[1], state_w[1], done_w[1]);
  endtask

  task automatic async_reset(input string tag);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    model_reset();
    check_all({tag, "_async"});
    @(posedge clk);
    #1 rst = 1'b0;
    check_all({tag, "_rel"});
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("t1_reset");
    rst = 1'b0;

    // 2: start, 11 ticks: 30 -> 29 at first tick, ends at 19
    step("t2_start", 0, 0, 1, 0, 0, 0);
    step("t2_tick1", 0, 0, 0, 1, 0, 0);
    check("t2_borrow", int'(digit1_w[0]) * 10 + int'(digit0_w[0]), 29);
    for (int i = 0; i < 10; i++) step("t2_tick", 0, 0, 0, 1, 0, 0);
    check("t2_nineteen", int'(digit1_w[0]) * 10 + int'(digit0_w[0]), 19);

    // 3: preset 02, count to 00, done pulse, no underflow
    step("t3_clear", 1, 0, 0, 0, 0, 0);
    step("t3_load", 0, 1, 0, 0, 0, 2);
    step("t3_start", 0, 0, 1, 0, 0, 0);
    step("t3_tick", 0, 0, 0, 1, 0, 0);
    step("t3_tick", 0, 0, 0, 1, 0, 0);
    check("t3_done", int'(done_w[0]), 1);
    check("t3_state", int'(state_w[0]), 3);
    step("t3_idle", 0, 0, 0, 0, 0, 0);
    step("t3_tick", 0, 0, 0, 1, 0, 0);

    // 4: start_stop + tick in RUN pauses without decrement
    step("t4_clear", 1, 0, 0, 0, 0, 0);
    step("t4_start", 0, 0, 1, 0, 0, 0);
    step("t4_tick", 0, 0, 0, 1, 0, 0);
    step("t4_pause", 0, 0, 1, 1, 0, 0);
    check("t4_paused", int'(digit1_w[0]) * 10 + int'(digit0_w[0]), 29);
    step("t4_tick", 0, 0, 0, 1, 0, 0);
    step("t4_tick", 0, 0, 0, 1, 0, 0);
    step("t4_resume", 0, 0, 1, 0, 0, 0);
    step("t4_tick", 0, 0, 0, 1, 0, 0);

    // 5: run down to 15, then clear+start_stop+tick together
    for (int i = 0; i < 13; i++) step("t5_tick", 0, 0, 0, 1, 0, 0);
    check("t5_at15", int'(digit1_w[0]) * 10 + int'(digit0_w[0]), 15);
    step("t5_all", 1, 0, 1, 1, 0, 0);
    check("t5_reload", int'(digit1_w[0]) * 10 + int'(digit0_w[0]), 30);

    // 6: wrap with preset 01, then clamped load in PAUSE
    step("t6_load", 0, 1, 0, 0, 0, 1);
    step("t6_start", 0, 0, 1, 0, 0, 0);
    step("t6_tick", 0, 0, 0, 1, 0, 0);
    check("t6_done_w1", int'(done_w[1]), 1);
    step("t6_wrap", 0, 0, 0, 1, 0, 0);
    check("t6_wrap_cnt", int'(digit1_w[1]) * 10 + int'(digit0_w[1]), 1);
    check("t6_wrap_run", int'(running_w[1]), 1);
    step("t6_pause", 0, 0, 1, 0, 0, 0);
    step("t6_load1F", 0, 1, 0, 0, 1, 15);
    check("t6_clamp", int'(digit1_w[1]) * 10 + int'(digit0_w[1]), 19);

    async_reset("t7");

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      bit c, l, s, t;
      c = ($urandom_range(0, 59) == 0);
      l = ($urandom_range(0, 24) == 0);
      s = ($urandom_range(0, 9) == 0);
      t = ($urandom_range(0, 1) == 0);
      if ($urandom_range(0, 499) == 0) async_reset("rnd");
      else step("rnd", c, l, s, t, int'($urandom_range(0, 15)),
                (($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(0, 15))));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
